// File: rtl/noc_inject_ni.sv
// noc_inject_ni -- network-interface injector feeding the router's local input channel.
// Turns local packet requests plus body words into flits, one flit per credit.
// Channel bit numbers: [0] valid, [1] head, [2] tail, [3] parity/rsvd, [67:4] payload.
// Optional feature: define NOC_INJECT_PARITY_EN to drive even parity over [67:4] on bit 3.
module noc_inject_ni #(
    parameter int CREDITS  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  NODE_ADDRESS,
    input  logic        PKT_VALID,
    input  logic [3:0]  PKT_DEST,
    input  logic [3:0]  PKT_LEN,
    output logic        PKT_READY,
    input  logic        DATA_VALID,
    input  logic [63:0] DATA,
    output logic        DATA_READY,
    output logic [67:0] CHANNEL_OUT,
    input  logic [1:0]  FLOW_CTRL_IN,
    output logic        ERROR,
    output logic        BUSY
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit_cnt;
    logic [3:0]          r_rem_cnt;
    logic [3:0]          w_rem_next;
    logic [67:0]         r_channel;
    logic [67:0]         w_flit_next;
    logic                r_error;
    logic                w_can_send;
    logic                w_pkt_hs;
    logic                w_data_hs;
    logic                w_send;
    logic                w_credit_ret;

    // A flit may launch only with a credit in hand and the router not halting us.
    assign w_can_send   = (r_credit_cnt != '0) && !FLOW_CTRL_IN[1];
    assign w_credit_ret = FLOW_CTRL_IN[0];

    // Ready outputs are held low during reset so nothing is accepted mid-reset.
    assign PKT_READY  = !reset && (r_state == ST_IDLE) && w_can_send;
    assign DATA_READY = !reset && (r_state == ST_BODY) && w_can_send;

    assign w_pkt_hs  = PKT_READY && PKT_VALID;
    assign w_data_hs = DATA_READY && DATA_VALID;
    assign w_send    = w_pkt_hs || w_data_hs;

    assign CHANNEL_OUT = r_channel;
    assign ERROR       = r_error;
    assign BUSY        = (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, remaining-body count and the flit to launch on the next edge.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem_cnt;
        w_flit_next  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pkt_hs) begin
                    w_flit_next[0]     = 1'b1;
                    w_flit_next[1]     = 1'b1;
                    w_flit_next[2]     = (PKT_LEN == 4'd0);
                    w_flit_next[7:4]   = PKT_DEST;
                    w_flit_next[11:8]  = NODE_ADDRESS;
                    w_flit_next[15:12] = PKT_LEN;
                    w_rem_next         = PKT_LEN;
                    if (PKT_LEN != 4'd0) begin
                        w_state_next = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_data_hs) begin
                    w_flit_next[0]    = 1'b1;
                    w_flit_next[2]    = (r_rem_cnt == 4'd1);
                    w_flit_next[67:4] = DATA;
                    w_rem_next        = r_rem_cnt - 4'd1;
                    if (r_rem_cnt == 4'd1) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
`ifdef NOC_INJECT_PARITY_EN
        w_flit_next[3] = w_flit_next[0] & (^w_flit_next[67:4]);
`else
        w_flit_next[3] = 1'b0;
`endif
    end

    // Channel register: a flit lives for exactly one cycle, idle cycles drive zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_channel <= '0;
            r_rem_cnt <= '0;
        end else begin
            r_channel <= w_flit_next;
            r_rem_cnt <= w_rem_next;
        end
    end

    // Credit counter and sticky overflow flag; a send and a return in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_cnt <= CREDIT_MAX;
            r_error      <= 1'b0;
        end else begin
            case ({w_send, w_credit_ret})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt == CREDIT_MAX) begin
                        r_error <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_inject_ni.sv
// Testbench for noc_inject_ni: directed scenarios followed by random traffic,
// all checked cycle by cycle against a packet-level reference model.
module tb_noc_inject_ni;

    localparam int CREDITS = 4;
`ifdef NOC_INJECT_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  node_address;
    logic        pkt_valid;
    logic [3:0]  pkt_dest;
    logic [3:0]  pkt_len;
    logic        pkt_ready;
    logic        data_valid;
    logic [63:0] data;
    logic        data_ready;
    logic [67:0] channel_out;
    logic [1:0]  flow_ctrl_in;
    logic        error;
    logic        busy;

    noc_inject_ni #(.CREDITS(CREDITS), .CREDIT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .NODE_ADDRESS (node_address),
        .PKT_VALID    (pkt_valid),
        .PKT_DEST     (pkt_dest),
        .PKT_LEN      (pkt_len),
        .PKT_READY    (pkt_ready),
        .DATA_VALID   (data_valid),
        .DATA         (data),
        .DATA_READY   (data_ready),
        .CHANNEL_OUT  (channel_out),
        .FLOW_CTRL_IN (flow_ctrl_in),
        .ERROR        (error),
        .BUSY         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet position, credits in hand, sticky error, flit due next.
    bit          m_in_body;
    int          m_rem;
    int          m_credits;
    bit          m_error;
    logic [67:0] m_flit;

    task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_body = 1'b0;
        m_rem     = 0;
        m_credits = CREDITS;
        m_error   = 1'b0;
        m_flit    = '0;
    endtask

    // Hold reset for n cycles and check the reset state.
    task automatic do_reset(input int n);
        reset        = 1'b1;
        pkt_valid    = 1'b0;
        data_valid   = 1'b0;
        flow_ctrl_in = 2'b00;
        repeat (n) @(posedge clk);
        #1;
        check_eq("rst_channel", channel_out, 68'h0);
        check_eq("rst_error", {67'h0, error}, 68'h0);
        check_eq("rst_busy", {67'h0, busy}, 68'h0);
        check_eq("rst_pkt_ready", {67'h0, pkt_ready}, 68'h0);
        check_eq("rst_data_ready", {67'h0, data_ready}, 68'h0);
        reset = 1'b0;
        model_reset();
        $display("reset %0d cycles", n);
    endtask

    // One clock cycle: drive inputs, check readies, advance model, check registered outputs.
    task automatic step(input logic [3:0] node, input logic pv, input logic [3:0] dest,
                        input logic [3:0] len, input logic dv, input logic [63:0] d,
                        input logic [1:0] fc);
        bit          can, exp_pr, exp_dr, pkt_hs, dat_hs, send;
        logic [67:0] nf;
        node_address = node;
        pkt_valid    = pv;
        pkt_dest     = dest;
        pkt_len      = len;
        data_valid   = dv;
        data         = d;
        flow_ctrl_in = fc;
        #1;
        can    = (m_credits > 0) && !fc[1];
        exp_pr = !m_in_body && can;
        exp_dr = m_in_body && can;
        check_eq("pkt_ready", {67'h0, pkt_ready}, {67'h0, exp_pr});
        check_eq("data_ready", {67'h0, data_ready}, {67'h0, exp_dr});
        pkt_hs = exp_pr && pv;
        dat_hs = exp_dr && dv;
        send   = pkt_hs || dat_hs;
        nf = '0;
        if (pkt_hs) begin
            nf[0]     = 1'b1;
            nf[1]     = 1'b1;
            nf[2]     = (len == 4'd0);
            nf[7:4]   = dest;
            nf[11:8]  = node;
            nf[15:12] = len;
            if (len != 0) begin
                m_in_body = 1'b1;
                m_rem     = int'(len);
            end
        end else if (dat_hs) begin
            nf[0]    = 1'b1;
            nf[2]    = (m_rem == 1);
            nf[67:4] = d;
            m_rem    = m_rem - 1;
            if (m_rem == 0) m_in_body = 1'b0;
        end
        if (nf[0] && PARITY_EN) nf[3] = ^nf[67:4];
        m_flit = nf;
        if (send && !fc[0]) begin
            m_credits = m_credits - 1;
        end else if (!send && fc[0]) begin
            if (m_credits == CREDITS) m_error = 1'b1;
            else m_credits = m_credits + 1;
        end
        @(posedge clk);
        #1;
        check_eq("channel", channel_out, m_flit);
        check_eq("error", {67'h0, error}, {67'h0, m_error});
        check_eq("busy", {67'h0, busy}, {67'h0, m_in_body});
        $display("cycle pv=%0b dv=%0b fc=%b hs=%0b%0b flit=%h credits=%0d err=%0b",
                 pv, dv, fc, pkt_hs, dat_hs, channel_out, m_credits, m_error);
    endtask

    // Return credits (no sends) until the model holds a full count.
    task automatic refill();
        while (m_credits < CREDITS) step(4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 2'b01);
    endtask

    initial begin
        reset        = 1'b1;
        node_address = 4'h3;
        pkt_valid    = 1'b0;
        pkt_dest     = 4'h0;
        pkt_len      = 4'h0;
        data_valid   = 1'b0;
        data         = 64'h0;
        flow_ctrl_in = 2'b00;
        model_reset();
        do_reset(2);

        // Head-only packet.
        step(4'h3, 1'b1, 4'hA, 4'h0, 1'b0, 64'h0, 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 2'b00);
        refill();

        // Credit stall: 5 body flits with no credit return, then two credit pulses.
        step(4'h3, 1'b1, 4'h5, 4'h5, 1'b0, 64'h0, 2'b00);
        for (int i = 1; i <= 4; i++) step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'(i), 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 2'b01);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h4, 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 2'b01);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h5, 2'b00);
        refill();

        // Simultaneous send and credit return.
        step(4'h3, 1'b1, 4'h7, 4'h2, 1'b0, 64'h0, 2'b01);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'hDEAD_BEEF, 2'b01);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'hCAFE_F00D, 2'b01);

        // Credit return while idle and full: sticky error.
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 2'b01);

        // Parity pattern on body flits.
        step(4'h3, 1'b1, 4'h1, 4'h2, 1'b0, 64'h0, 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h1, 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h3, 2'b00);
        refill();

        // Halt for 3 cycles mid-body.
        step(4'h3, 1'b1, 4'h2, 4'h4, 1'b0, 64'h0, 2'b01);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h11, 2'b01);
        for (int i = 0; i < 3; i++) step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h22, 2'b10);
        for (int i = 2; i <= 4; i++) step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'(i * 17), 2'b01);

        // Reset mid-body, then exactly four head-only packets fit in the credits.
        step(4'h3, 1'b1, 4'h9, 4'h5, 1'b0, 64'h0, 2'b00);
        step(4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 64'h77, 2'b00);
        do_reset(2);
        for (int i = 0; i < 5; i++) step(4'h3, 1'b1, 4'(i), 4'h0, 1'b0, 64'h0, 2'b00);
        refill();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7),
                 {$urandom, $urandom},
                 {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
